iter_div_unit: RTL

- Multi-cycle integer divide functional unit for PISA DIV/DIVU. It sits directly downstream of register read and consumes the same fuPkt fields that register read produces: opcode, source data, phyDest, alID and valid.
- Radix-2 restoring divider. Produces quotient (LO) and remainder (HI) with a one-cycle writeback pulse toward the bypass/writeback network.
- Asserts busy_o so the issue logic does not select another divide while one is in flight.

---
 rtl/iter_div_unit_pkg.sv | 40 ++++
 rtl/iter_div_unit_if.sv | 58 +++++
 rtl/div_restore_step.sv | 36 +++
 rtl/iter_div_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/iter_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// iter_div_unit_pkg
// Shared definitions for the iterative divide functional unit: the DIV/DIVU
// opcode encodings, the divider FSM state type and the fixed divide latency
// that issue-side scoreboarding uses to predict writeback.
// Optional feature macro (consumed by iter_div_unit): DIV_EARLY_OUT_EN.
// ---------------------------------------------------------------------------
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 8
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif
`ifndef SIZE_ACTIVELIST_LOG
`define SIZE_ACTIVELIST_LOG 7
`endif

package iter_div_unit_pkg;

  localparam int OPCODE_W = `SIZE_OPCODE_I;

  // Signed and unsigned divide opcodes as they arrive in the fuPkt.
  localparam logic [OPCODE_W-1:0] OP_DIV  = OPCODE_W'(8'h1A);
  localparam logic [OPCODE_W-1:0] OP_DIVU = OPCODE_W'(8'h1B);

  // Cycles from the accepting edge to the cycle in which wbValid_o is
  // high: one iteration per data bit, plus the FIX and DONE cycles.
  localparam int DIV_LATENCY = `SIZE_DATA + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } divState_t;

endpackage

// File: rtl/iter_div_unit_if.sv
// ---------------------------------------------------------------------------
// iter_div_unit_if
// Bundles the divider's issue-side fuPkt fields and its writeback-side
// result fields.
//   master : register-read / issue side (drives the request, sees results)
//   slave  : the divide unit
// Request : recoverFlag_i, valid_i, opcode_i, src1Data_i, src2Data_i,
//           phyDest_i, alID_i
// Response: busy_o, wbValid_o, wbPhyDest_o, wbAlID_o, quotient_o,
//           remainder_o
// ---------------------------------------------------------------------------
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 8
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif
`ifndef SIZE_ACTIVELIST_LOG
`define SIZE_ACTIVELIST_LOG 7
`endif

interface iter_div_unit_if #(
  parameter int DATA_WIDTH = `SIZE_DATA
);

  logic                            recoverFlag_i;
  logic                            valid_i;
  logic [`SIZE_OPCODE_I-1:0]       opcode_i;
  logic [DATA_WIDTH-1:0]           src1Data_i;
  logic [DATA_WIDTH-1:0]           src2Data_i;
  logic [`SIZE_PHYSICAL_LOG-1:0]   phyDest_i;
  logic [`SIZE_ACTIVELIST_LOG-1:0] alID_i;

  logic                            busy_o;
  logic                            wbValid_o;
  logic [`SIZE_PHYSICAL_LOG-1:0]   wbPhyDest_o;
  logic [`SIZE_ACTIVELIST_LOG-1:0] wbAlID_o;
  logic [DATA_WIDTH-1:0]           quotient_o;
  logic [DATA_WIDTH-1:0]           remainder_o;

  modport master (
    output recoverFlag_i, valid_i, opcode_i, src1Data_i, src2Data_i,
           phyDest_i, alID_i,
    input  busy_o, wbValid_o, wbPhyDest_o, wbAlID_o, quotient_o,
           remainder_o
  );

  modport slave (
    input  recoverFlag_i, valid_i, opcode_i, src1Data_i, src2Data_i,
           phyDest_i, alID_i,
    output busy_o, wbValid_o, wbPhyDest_o, wbAlID_o, quotient_o,
           remainder_o
  );

endinterface

// File: rtl/div_restore_step.sv
// ---------------------------------------------------------------------------
// div_restore_step
// One radix-2 restoring division step, purely combinational.
//   rem_i, quot_i  : current partial remainder and quotient/dividend shifter
//   divisor_i      : divisor magnitude
//   rem_o, quot_o  : values after shifting {rem, quot} left by one and
//                    conditionally subtracting the divisor
// ---------------------------------------------------------------------------
module div_restore_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic [DATA_WIDTH-1:0] quot_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic [DATA_WIDTH-1:0] quot_o
);

  logic [DATA_WIDTH:0]   remShift;
  logic [DATA_WIDTH-1:0] trial;
  logic                  fits;

  // The shifted remainder can exceed DATA_WIDTH bits (e.g. an unsigned
  // divisor near 2^DATA_WIDTH), so the "trial is non-negative" test is a
  // full-width compare. When it fits, the true difference is below the
  // divisor and therefore fits in DATA_WIDTH bits, so the narrow subtract
  // is exact.
  always_comb begin
    remShift = {rem_i, quot_i[DATA_WIDTH-1]};
    fits     = (remShift >= {1'b0, divisor_i});
    trial    = remShift[DATA_WIDTH-1:0] - divisor_i;
    rem_o    = fits ? trial : remShift[DATA_WIDTH-1:0];
    quot_o   = {quot_i[DATA_WIDTH-2:0], fits};
  end

endmodule

// File: rtl/iter_div_unit.sv
// ---------------------------------------------------------------------------
// iter_div_unit
// Multi-cycle radix-2 restoring divider for DIV (signed) and DIVU
// (unsigned). Quotient goes to LO, remainder to HI, with a one-cycle
// writeback pulse.
// Ports:
//   clk    : core clock
//   reset  : asynchronous active-high reset
//   divIf  : iter_div_unit_if.slave - fuPkt request in, busy and writeback
//            results out
// Optional feature macro: DIV_EARLY_OUT_EN - when defined, a divide whose
// dividend magnitude is below a non-zero divisor magnitude skips the
// iterations and goes straight to sign correction.
// ---------------------------------------------------------------------------
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif
`ifndef SIZE_ACTIVELIST_LOG
`define SIZE_ACTIVELIST_LOG 7
`endif

module iter_div_unit
  import iter_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = `SIZE_DATA,
  parameter int CNT_WIDTH  = 6
) (
  input logic           clk,
  input logic           reset,
  iter_div_unit_if.slave divIf
);

  divState_t                       stateQ, stateD;
  logic [DATA_WIDTH-1:0]           remQ, remD;
  logic [DATA_WIDTH-1:0]           quotQ, quotD;
  logic [DATA_WIDTH-1:0]           divisorQ, divisorD;
  logic [CNT_WIDTH-1:0]            countQ, countD;
  logic                            quotNegQ, quotNegD;
  logic                            remNegQ, remNegD;
  logic                            divZeroQ, divZeroD;
  logic [`SIZE_PHYSICAL_LOG-1:0]   phyDestQ, phyDestD;
  logic [`SIZE_ACTIVELIST_LOG-1:0] alIDQ, alIDD;
  logic [`SIZE_PHYSICAL_LOG-1:0]   wbPhyDestQ, wbPhyDestD;
  logic [`SIZE_ACTIVELIST_LOG-1:0] wbAlIDQ, wbAlIDD;
  logic [DATA_WIDTH-1:0]           quotientQ, quotientD;
  logic [DATA_WIDTH-1:0]           remainderQ, remainderD;

  logic                  isDivOp, isSigned, accept, earlyOut;
  logic                  src1Neg, src2Neg;
  logic [DATA_WIDTH-1:0] mag1, mag2;
  logic [DATA_WIDTH-1:0] stepRem, stepQuot;

  // Request decode: only DIV/DIVU are ours, and a flush cycle never starts
  // a divide. Operand magnitudes are taken only for the signed opcode.
  always_comb begin
    isSigned = (divIf.opcode_i == OP_DIV);
    isDivOp  = isSigned || (divIf.opcode_i == OP_DIVU);
    accept   = (stateQ == IDLE) && divIf.valid_i && isDivOp &&
               !divIf.recoverFlag_i;
    src1Neg  = isSigned && divIf.src1Data_i[DATA_WIDTH-1];
    src2Neg  = isSigned && divIf.src2Data_i[DATA_WIDTH-1];
    mag1     = src1Neg ? -divIf.src1Data_i : divIf.src1Data_i;
    mag2     = src2Neg ? -divIf.src2Data_i : divIf.src2Data_i;
  end

`ifdef DIV_EARLY_OUT_EN
  // Quotient is trivially zero when the dividend is smaller than the divisor.
  assign earlyOut = (mag2 != '0) && (mag1 < mag2);
`else
  assign earlyOut = 1'b0;
`endif

  div_restore_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) uStep (
    .rem_i     (remQ),
    .quot_i    (quotQ),
    .divisor_i (divisorQ),
    .rem_o     (stepRem),
    .quot_o    (stepQuot)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // FSM next-state logic. A flush wins over everything and returns to IDLE.
  always_comb begin
    stateD = stateQ;
    if (divIf.recoverFlag_i) begin
      stateD = IDLE;
    end else begin
      case (stateQ)
        IDLE:    if (accept) stateD = earlyOut ? FIX : ITER;
        ITER:    if (countQ == CNT_WIDTH'(1)) stateD = FIX;
        FIX:     stateD = DONE;
        DONE:    stateD = IDLE;
        default: stateD = IDLE;
      endcase
    end
  end

  // FSM outputs. Writeback is gated by the flush combinationally so a
  // flush landing in the DONE cycle still suppresses the pulse.
  always_comb begin
    divIf.busy_o    = (stateQ != IDLE);
    divIf.wbValid_o = (stateQ == DONE) && !divIf.recoverFlag_i;
  end

  // Datapath next-state. On accept the operands are loaded as magnitudes;
  // the remainder accumulator starts at zero and the dividend sits in the
  // quotient shifter. FIX applies sign correction and publishes results.
  // A flush only clears the counter; result outputs keep their last values.
  always_comb begin
    remD        = remQ;
    quotD       = quotQ;
    divisorD    = divisorQ;
    countD      = countQ;
    quotNegD    = quotNegQ;
    remNegD     = remNegQ;
    divZeroD    = divZeroQ;
    phyDestD    = phyDestQ;
    alIDD       = alIDQ;
    wbPhyDestD  = wbPhyDestQ;
    wbAlIDD     = wbAlIDQ;
    quotientD   = quotientQ;
    remainderD  = remainderQ;
    if (divIf.recoverFlag_i) begin
      countD = '0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (accept) begin
            phyDestD = divIf.phyDest_i;
            alIDD    = divIf.alID_i;
            quotNegD = src1Neg ^ src2Neg;
            remNegD  = src1Neg;
            divZeroD = (mag2 == '0);
            divisorD = mag2;
            countD   = CNT_WIDTH'(DATA_WIDTH);
            if (earlyOut) begin
              quotD = '0;
              remD  = mag1;
            end else begin
              quotD = mag1;
              remD  = '0;
            end
          end
        end
        ITER: begin
          remD   = stepRem;
          quotD  = stepQuot;
          countD = countQ - CNT_WIDTH'(1);
        end
        FIX: begin
          // Divide by zero: the restoring loop yields all-ones and |src1|;
          // the quotient is forced and the remainder's sign restore gives
          // back the original dividend bit pattern.
          if (divZeroQ) begin
            quotientD = '1;
          end else begin
            quotientD = quotNegQ ? -quotQ : quotQ;
          end
          remainderD = remNegQ ? -remQ : remQ;
          wbPhyDestD = phyDestQ;
          wbAlIDD    = alIDQ;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remQ       <= '0;
      quotQ      <= '0;
      divisorQ   <= '0;
      countQ     <= '0;
      quotNegQ   <= 1'b0;
      remNegQ    <= 1'b0;
      divZeroQ   <= 1'b0;
      phyDestQ   <= '0;
      alIDQ      <= '0;
      wbPhyDestQ <= '0;
      wbAlIDQ    <= '0;
      quotientQ  <= '0;
      remainderQ <= '0;
    end else begin
      remQ       <= remD;
      quotQ      <= quotD;
      divisorQ   <= divisorD;
      countQ     <= countD;
      quotNegQ   <= quotNegD;
      remNegQ    <= remNegD;
      divZeroQ   <= divZeroD;
      phyDestQ   <= phyDestD;
      alIDQ      <= alIDD;
      wbPhyDestQ <= wbPhyDestD;
      wbAlIDQ    <= wbAlIDD;
      quotientQ  <= quotientD;
      remainderQ <= remainderD;
    end
  end

  assign divIf.wbPhyDest_o = wbPhyDestQ;
  assign divIf.wbAlID_o    = wbAlIDQ;
  assign divIf.quotient_o  = quotientQ;
  assign divIf.remainder_o = remainderQ;

`ifndef SYNTHESIS
  // Issue must not present another divide while one is in flight.
  noDivWhileBusy: assert property (@(posedge clk) disable iff (reset)
    !((stateQ != IDLE) && divIf.valid_i && isDivOp && !divIf.recoverFlag_i));
`endif

endmodule
